// File: rtl/poly_addsub_seq_if.sv
// Job/result handshake bundle for the sequential modular polynomial add/subtract unit.
// The producer side drives operands and accepts results (master); the unit is the slave.
interface poly_addsub_seq_if #(
    parameter int unsigned DEG = 256,
    parameter int unsigned N   = 12
);
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [DEG*N-1:0] a;
    logic [DEG*N-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [DEG*N-1:0] s;
    logic             busy;

    modport master (
        output in_valid, mode, a, b, out_ready,
        input  in_ready, out_valid, s, busy
    );

    modport slave (
        input  in_valid, mode, a, b, out_ready,
        output in_ready, out_valid, s, busy
    );
endinterface

// File: rtl/poly_addsub_seq.sv
// Sequential modular polynomial add/subtract: s[i] = (a[i] +/- b[i]) mod Q,
// LANES coefficients per clock, operands latched on acceptance, result held until taken.
module poly_addsub_seq #(
    parameter int unsigned DEG   = 256,
    parameter int unsigned N     = 12,
    parameter int unsigned Q     = 3329,
    parameter int unsigned LANES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    poly_addsub_seq_if.slave        bus
);
    localparam int unsigned BEATS = DEG / LANES;
    localparam int unsigned SEG   = LANES * N;
    localparam int unsigned W     = DEG * N;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned IW    = (W > 1) ? $clog2(W) : 1;

    localparam logic [N:0]    QW   = (N+1)'(Q);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (DEG % LANES != 0) begin : g_chk_lanes
        $error("poly_addsub_seq: LANES must divide DEG");
    end
    if (64'(Q) > (64'd1 << N)) begin : g_chk_qmax
        $error("poly_addsub_seq: Q must not exceed 2**N");
    end
    if (Q < 2) begin : g_chk_qmin
        $error("poly_addsub_seq: Q must be at least 2");
    end

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic           w_accept;
    logic           w_beat;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_mode;
    logic [W-1:0]   r_s;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_busy;
    logic [IW-1:0]  w_base;
    logic [SEG-1:0] w_a_seg;
    logic [SEG-1:0] w_b_seg;
    logic [SEG-1:0] w_res;

    // Next-state and datapath enables
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_beat = 1'b1;
                if (r_cnt == LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; handshake outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DONE);
        end
    end

    assign w_base  = IW'(r_cnt) * IW'(SEG);
    assign w_a_seg = r_a[w_base +: SEG];
    assign w_b_seg = r_b[w_base +: SEG];

    // One conditional correction per lane; N+1 bits hold both the carry and the borrow sign
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [N:0]   w_add;
        logic [N:0]   w_sub;
        logic [N-1:0] w_add_res;
        logic [N-1:0] w_sub_res;

        assign w_add     = {1'b0, w_a_seg[g*N +: N]} + {1'b0, w_b_seg[g*N +: N]};
        assign w_sub     = {1'b0, w_a_seg[g*N +: N]} - {1'b0, w_b_seg[g*N +: N]};
        assign w_add_res = N'((w_add >= QW) ? (w_add - QW) : w_add);
        assign w_sub_res = N'(w_sub[N] ? (w_sub + QW) : w_sub);
        assign w_res[g*N +: N] = r_mode ? w_sub_res : w_add_res;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_mode <= 1'b0;
            r_cnt  <= '0;
            r_s    <= '0;
        end else begin
            if (w_accept) begin
                r_a    <= bus.a;
                r_b    <= bus.b;
                r_mode <= bus.mode;
                r_cnt  <= '0;
            end
            if (w_beat) begin
                r_s[w_base +: SEG] <= w_res;
                r_cnt              <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.s         = r_s;
endmodule

// File: tb/tb_poly_addsub_seq.sv
// Directed bench for poly_addsub_seq: a tiny wrap-around config and a Q=3329 config
// side by side, covering arithmetic corners, latency, backpressure, reset and streaming.
module tb_poly_addsub_seq;
    localparam int unsigned A_DEG = 4;
    localparam int unsigned A_N   = 4;
    localparam int unsigned A_Q   = 16;
    localparam int unsigned A_L   = 1;
    localparam int unsigned B_DEG = 8;
    localparam int unsigned B_N   = 12;
    localparam int unsigned B_Q   = 3329;
    localparam int unsigned B_L   = 2;
    localparam int unsigned LAT   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          n_err = 0;
    int          n_chk = 0;

    int unsigned mix_a [8] = '{3000, 100, 3328, 0, 1234, 3000, 5, 2000};
    int unsigned mix_b [8] = '{329, 200, 3328, 0, 1000, 500, 10, 1329};
    int unsigned mix_add [8] = '{0, 300, 3327, 0, 2234, 171, 15, 0};
    int unsigned mix_sub [8] = '{2671, 3229, 0, 0, 234, 2500, 3324, 671};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    poly_addsub_seq_if #(.DEG(A_DEG), .N(A_N)) bus_a ();
    poly_addsub_seq_if #(.DEG(B_DEG), .N(B_N)) bus_b ();

    poly_addsub_seq #(.DEG(A_DEG), .N(A_N), .Q(A_Q), .LANES(A_L)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    poly_addsub_seq #(.DEG(B_DEG), .N(B_N), .Q(B_Q), .LANES(B_L)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic chk_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] fill_b(input logic [11:0] v);
        return {8{v}};
    endfunction

    function automatic logic [95:0] pack8(input int unsigned v [8]);
        logic [95:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*12 +: 12] = 12'(v[i]);
        return r;
    endfunction

    function automatic logic [95:0] ref_b(input logic md, input logic [95:0] a, input logic [95:0] b);
        logic [95:0] r;
        int          x;
        int          y;
        int          t;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            x = int'(a[i*12 +: 12]);
            y = int'(b[i*12 +: 12]);
            if (md) begin
                t = x - y;
                if (t < 0) t = t + int'(B_Q);
            end else begin
                t = x + y;
                if (t >= int'(B_Q)) t = t - int'(B_Q);
            end
            r[i*12 +: 12] = 12'(t);
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic start_b(input logic md, input logic [95:0] a, input logic [95:0] b,
                           input bit hold, output int unsigned acc);
        int k;
        k = 0;
        while (!bus_b.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        bus_b.mode     = md;
        bus_b.a        = a;
        bus_b.b        = b;
        bus_b.in_valid = 1'b1;
        @(negedge clk);
        acc = cyc;
        if (!hold) bus_b.in_valid = 1'b0;
    endtask

    task automatic wait_out_b(input int unsigned acc, output int unsigned lat);
        int k;
        k = 0;
        while (!bus_b.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        lat = cyc - acc;
    endtask

    task automatic job_b(input string tag, input logic md, input logic [95:0] a,
                         input logic [95:0] b, input logic [95:0] exp);
        int unsigned acc;
        int unsigned lat;
        start_b(md, a, b, 1'b0, acc);
        wait_out_b(acc, lat);
        chk_eq({tag, "_lat"}, 96'(lat), 96'(LAT));
        chk_eq({tag, "_s"}, bus_b.s, exp);
        bus_b.out_ready = 1'b1;
        @(negedge clk);
        bus_b.out_ready = 1'b0;
        chk_eq({tag, "_rdy"}, 96'(bus_b.in_ready), 96'(1));
        chk_eq({tag, "_keep"}, bus_b.s, exp);
    endtask

    task automatic job_a(input string tag, input logic md, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp);
        int unsigned acc;
        int          k;
        k = 0;
        while (!bus_a.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        bus_a.mode     = md;
        bus_a.a        = a;
        bus_a.b        = b;
        bus_a.in_valid = 1'b1;
        @(negedge clk);
        acc = cyc;
        bus_a.in_valid = 1'b0;
        k = 0;
        while (!bus_a.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk_eq({tag, "_lat"}, 96'(cyc - acc), 96'(LAT));
        chk_eq({tag, "_s"}, 96'(bus_a.s), 96'(exp));
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        bus_a.out_ready = 1'b0;
        chk_eq({tag, "_rdy"}, 96'(bus_a.in_ready), 96'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned acc;
        int unsigned lat;
        int unsigned prev;
        logic [95:0] ta;
        logic [95:0] tb_v;
        logic [95:0] exp;
        logic        md;

        rst_n = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.mode = 1'b0; bus_a.a = '0; bus_a.b = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.mode = 1'b0; bus_b.a = '0; bus_b.b = '0; bus_b.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk_eq("rst_a_in_ready", 96'(bus_a.in_ready), 96'(1));
        chk_eq("rst_a_out_valid", 96'(bus_a.out_valid), 96'(0));
        chk_eq("rst_b_in_ready", 96'(bus_b.in_ready), 96'(1));
        chk_eq("rst_b_busy", 96'(bus_b.busy), 96'(0));
        chk_eq("rst_b_s", bus_b.s, 96'(0));

        // Q = 2**N: plain wrap-around per coefficient
        job_a("a_add", 1'b0, 16'hAA5F, 16'hAA5F, 16'h44AE);
        job_a("a_sub", 1'b1, 16'h1234, 16'h4321, 16'hDF13);

        // Q = 3329 corners
        job_b("b_add_wrap", 1'b0, fill_b(12'd3328), fill_b(12'd1), 96'(0));
        job_b("b_sub_borrow", 1'b1, fill_b(12'd0), fill_b(12'd1), fill_b(12'd3328));
        job_b("b_add_noreduce", 1'b0, fill_b(12'd1664), fill_b(12'd1664), fill_b(12'd3328));
        job_b("b_add_mix", 1'b0, pack8(mix_a), pack8(mix_b), pack8(mix_add));
        job_b("b_sub_mix", 1'b1, pack8(mix_a), pack8(mix_b), pack8(mix_sub));

        // Backpressure in DONE
        start_b(1'b0, fill_b(12'd1664), fill_b(12'd1), 1'b0, acc);
        wait_out_b(acc, lat);
        chk_eq("bp_lat", 96'(lat), 96'(LAT));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_eq("bp_out_valid", 96'(bus_b.out_valid), 96'(1));
            chk_eq("bp_in_ready", 96'(bus_b.in_ready), 96'(0));
            chk_eq("bp_s", bus_b.s, fill_b(12'd1665));
        end
        bus_b.out_ready = 1'b1;
        @(negedge clk);
        bus_b.out_ready = 1'b0;
        chk_eq("bp_release_rdy", 96'(bus_b.in_ready), 96'(1));
        chk_eq("bp_release_valid", 96'(bus_b.out_valid), 96'(0));

        // Reset after the second RUN beat
        start_b(1'b0, fill_b(12'd5), fill_b(12'd7), 1'b0, acc);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_eq("mid_rst_in_ready", 96'(bus_b.in_ready), 96'(1));
        chk_eq("mid_rst_out_valid", 96'(bus_b.out_valid), 96'(0));
        chk_eq("mid_rst_busy", 96'(bus_b.busy), 96'(0));
        chk_eq("mid_rst_s", bus_b.s, 96'(0));
        @(negedge clk);
        chk_eq("mid_rst_idle", 96'(bus_b.out_valid), 96'(0));
        job_b("post_rst", 1'b1, fill_b(12'd7), fill_b(12'd5), fill_b(12'd2));

        // Streaming with in_valid and out_ready held high
        bus_b.out_ready = 1'b1;
        prev = 0;
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < 8; i++) begin
                ta[i*12 +: 12]   = 12'((j*37 + i*411) % 3329);
                tb_v[i*12 +: 12] = 12'((j*913 + i*97 + 5) % 3329);
            end
            md  = j[0];
            exp = ref_b(md, ta, tb_v);
            start_b(md, ta, tb_v, 1'b1, acc);
            if (j > 0) chk_eq("stream_period", 96'(acc - prev), 96'(LAT + 2));
            wait_out_b(acc, lat);
            chk_eq("stream_lat", 96'(lat), 96'(LAT));
            chk_eq("stream_s", bus_b.s, exp);
            chk_eq("stream_done_rdy", 96'(bus_b.in_ready), 96'(0));
            @(negedge clk);
            chk_eq("stream_no_dup", 96'(bus_b.out_valid), 96'(0));
            chk_eq("stream_idle_rdy", 96'(bus_b.in_ready), 96'(1));
            prev = acc;
        end
        bus_b.in_valid  = 1'b0;
        bus_b.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
